// File: rtl/riscv_types.sv
// Shared RISC-V core types: store widths plus the memory-port arbiter state and owner encodings.
package riscv_types;

  typedef enum logic [1:0] {
    STORE_BYTE     = 2'b00,
    STORE_HALFWORD = 2'b01,
    STORE_WORD     = 2'b10
  } store_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_IF = 2'b01,
    GNT_DM = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_streak_cnt.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module mem_arb_streak_cnt #(
  parameter int MAX_COUNT = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               inc,
  input  logic                               clr,
  output logic [$clog2(MAX_COUNT+1)-1:0]     count,
  output logic                               at_max
);

  localparam int CW = $clog2(MAX_COUNT + 1);

  assign at_max = (count == CW'(MAX_COUNT));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch and data; data wins unless fetch has been starved.
// Optional bus timeout with bus_err output when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import riscv_types::*;
#(
  parameter int MAX_DM_STREAK  = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_store_type,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_store_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic        bus_err,
`endif
  output logic [1:0]  owner
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  arb_state_t  state_reg, state_next;
  logic        mem_req_next, mem_we_next;
  logic [1:0]  mem_store_type_next, owner_next;
  logic [31:0] mem_addr_next, mem_wdata_next;

  logic [SW-1:0] streak_count;
  logic          streak_at_max;
  logic          streak_inc, streak_clr;
  logic          dm_win, if_win, done, timeout_hit;

  mem_arb_streak_cnt #(.MAX_COUNT(MAX_DM_STREAK)) u_streak (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (streak_inc),
    .clr     (streak_clr),
    .count   (streak_count),
    .at_max  (streak_at_max)
  );

  // Data wins unless fetch is also waiting and the streak limit has been hit.
  assign dm_win = (state_reg == IDLE) && dm_req &&
                  (!if_req || (streak_count < SW'(MAX_DM_STREAK)));
  assign if_win = (state_reg == IDLE) && if_req && !dm_win;

  assign streak_inc = dm_win && if_req && !streak_at_max;
  assign streak_clr = if_win || (dm_win && !if_req);

`ifdef ARB_TIMEOUT_EN
  localparam int BW = $clog2(TIMEOUT_CYCLES + 1);
  logic [BW-1:0] busy_reg, busy_next;

  // Fires in the TIMEOUT_CYCLES-th busy cycle; a real ack in that cycle still wins.
  assign timeout_hit = (state_reg != IDLE) && !mem_ack && (busy_reg == BW'(TIMEOUT_CYCLES - 1));
  assign bus_err     = reset_n && timeout_hit;

  always_comb begin
    busy_next = busy_reg;
    if (dm_win || if_win) begin
      busy_next = '0;
    end else if (state_reg != IDLE && !mem_ack) begin
      busy_next = busy_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = mem_ack || timeout_hit;

  always_comb begin
    state_next          = state_reg;
    mem_req_next        = mem_req;
    mem_we_next         = mem_we;
    mem_store_type_next = mem_store_type;
    mem_addr_next       = mem_addr;
    mem_wdata_next      = mem_wdata;
    owner_next          = owner;
    if_ack              = 1'b0;
    dm_ack              = 1'b0;
    if_rdata            = '0;
    dm_rdata            = '0;
    case (state_reg)
      IDLE: begin
        if (dm_win) begin
          state_next          = GNT_DM;
          mem_req_next        = 1'b1;
          mem_we_next         = dm_we;
          mem_store_type_next = dm_store_type;
          mem_addr_next       = dm_addr;
          mem_wdata_next      = dm_wdata;
          owner_next          = OWN_DM;
        end else if (if_win) begin
          state_next          = GNT_IF;
          mem_req_next        = 1'b1;
          mem_we_next         = 1'b0;
          mem_store_type_next = STORE_WORD;
          mem_addr_next       = if_addr;
          mem_wdata_next      = '0;
          owner_next          = OWN_IF;
        end
      end
      GNT_IF, GNT_DM: begin
        // Acks are suppressed under reset so an abandoned transfer never completes.
        if (done && reset_n) begin
          if (state_reg == GNT_IF) begin
            if_ack   = 1'b1;
            if_rdata = mem_ack ? mem_rdata : '0;
          end else begin
            dm_ack   = 1'b1;
            dm_rdata = mem_ack ? mem_rdata : '0;
          end
        end
        if (done) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          owner_next   = OWN_NONE;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        owner_next   = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_store_type <= 2'b00;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      owner          <= OWN_NONE;
    end else begin
      state_reg      <= state_next;
      mem_req        <= mem_req_next;
      mem_we         <= mem_we_next;
      mem_store_type <= mem_store_type_next;
      mem_addr       <= mem_addr_next;
      mem_wdata      <= mem_wdata_next;
      owner          <= owner_next;
    end
  end

endmodule
